// File: rtl/serial_tx_if.sv
// Word handshake between a producer and the serial_tx frame transmitter.
// The producer drives data_in/valid; the transmitter answers with ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, data LSB-first, optional even parity, stop bit.
// Each bit is held for CLKS_PER_BIT clocks; tx/busy/done are registered, ready is decoded from state.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       clear,
  serial_tx_if.slave bus,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [IW-1:0]     bit_idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [DATA_W-1:0] shift_dn;

  // Next data bit is read from the pre-shifted word so tx updates on the same edge as the shift.
  assign shift_dn  = shift_reg >> 1;
  assign bus.ready = (state_reg == IDLE);
  assign tx        = tx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg      <= 1'b1;
          busy_reg    <= 1'b0;
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          if (bus.valid) begin
            shift_reg  <= bus.data_in;
            parity_reg <= ^bus.data_in;
            state_reg  <= START;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
          end
        end

        START: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= shift_dn;
            if (bit_idx_reg == IDX_LAST) begin
              bit_idx_reg <= '0;
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              tx_reg      <= shift_dn[0];
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        PARITY: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        STOP: begin
          // Leaving STOP: the first IDLE cycle carries the done pulse and may accept a new word.
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial frame transmitter: the drive side of a single-wire synchronous serial link.
- Accepts a DATA_W-bit word through a valid/ready handshake and emits it on one output line as a frame: start bit, data LSB-first, optional even-parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- The matching receiver samples the same line with flip-flops clocked by the same clk.

Parameters:
- DATA_W, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).
- PARITY_EN, 1, 1 = insert even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous active-low reset; sampled on rising clk.
- data_in  input  DATA_W  word to send; sampled only on handshake.
- valid  input  1  data_in is valid.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset: clear=0 at a rising edge forces state IDLE and all counters to 0.
  - tx=1, busy=0, done=0, ready=1 after that edge.
  - Takes effect mid-frame too: the frame is aborted and tx returns high the next cycle.
- tx, busy and done are registered. ready is combinational and equals (state==IDLE).
- Handshake: the word is accepted when valid=1 and ready=1 at a rising edge.
  - data_in is latched into a shift register and the parity bit (XOR of data_in) is latched at the same edge.
  - valid while ready=0 is ignored; no queueing.
  - Changes on data_in after acceptance do not affect the frame.
- FSM states:
  - IDLE: tx=1. On accept -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx = shift-register bit 0, held CLKS_PER_BIT cycles; then shift right and bit index +1. After bit DATA_W-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx = latched parity for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE, with done=1 in the first IDLE cycle.
- Timing:
  - tx reflects the new state starting the cycle after the transition edge.
  - First start-bit cycle is the cycle after the accept edge.
  - Frame length = (DATA_W + PARITY_EN + 2) * CLKS_PER_BIT cycles; 44 for the defaults.
- busy=1 from the cycle after accept through the last STOP cycle; 0 in IDLE.
- Back-to-back: a word may be accepted in the done cycle. The line then holds tx=1 for that single IDLE cycle plus the stop bit before the next start bit.
- Counters:
  - Bit-period counter: width max(1,$clog2(CLKS_PER_BIT)), counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit change.
  - Bit index: width max(1,$clog2(DATA_W)).
  - With CLKS_PER_BIT=1 every bit lasts exactly one cycle; no off-by-one allowed.
- Simultaneous events:
  - clear=0 with valid=1: reset wins; the word is not accepted.
  - valid arriving in the same cycle the FSM leaves STOP is not accepted; ready is still 0 that cycle.

Test Plan:
- Reset then idle: clear=0 for 2 cycles, then 1 -> tx=1, ready=1, busy=0, done=0; stay so for 10 cycles with valid=0.
- Single frame, defaults: send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit exactly 4 cycles; busy=1 for 44 cycles; done pulses 1 cycle after.
- Ignore during busy: send 0x0F, then pulse valid with data_in=0xFF mid-frame and change data_in -> line carries 0x0F frame unchanged (parity 0); 0xFF never transmitted.
- Back-to-back: valid held high with 0x01 then 0x80 -> second start bit begins the cycle after the done-cycle accept; the two frames are separated by exactly one extra idle-high cycle. 0x01 parity=1; 0x80 parity=1.
- Reset mid-frame: assert clear=0 during data bit 3 of 0x3C -> tx=1, busy=0 the next cycle; a subsequent 0x55 frame is transmitted correctly from its start bit.
- Parameter corner: PARITY_EN=0, CLKS_PER_BIT=1, DATA_W=8, send 0x01 -> tx 0,1,0,0,0,0,0,0,0,1 one cycle each; frame is 10 cycles; no parity bit.
